tape_adc_slicer: RTL and testbench

Parametrised ADC-to-bit slicer for the cassette input path. Consumes toggle-strobed samples from the ADC interface (ltc2308 style) and keeps a running average over a power-of-two window in a circular RAM instead of a shift register. It slices each sample against that average with symmetric hysteresis and drives a one-bit tape signal toward the core's tape input. It also reports the running average, a primed flag and, optionally, a tape-activity flag.

---
 rtl/tape_adc_slicer_if.sv | 24 ++
 rtl/tape_adc_slicer.sv | 133 +++++++++++++
 tb/tb_tape_adc_slicer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tape_adc_slicer_if.sv
// Sample and result bundle of the cassette ADC slicer.
// The ADC side (master) drives the toggle-strobed sample.
// The slicer (slave) returns the sliced bit, the average and the status flags.
interface tape_adc_slicer_if #(
   parameter int DW = 12
);
   logic [DW-1:0] adc_data;
   logic          adc_sync;
   logic          dout;
   logic [DW-1:0] avg;
   logic          primed;
   logic          sample_valid;
   logic          active;

   modport master (
      output adc_data, adc_sync,
      input  dout, avg, primed, sample_valid, active
   );

   modport slave (
      input  adc_data, adc_sync,
      output dout, avg, primed, sample_valid, active
   );
endinterface

// File: rtl/tape_adc_slicer.sv
// tape_adc_slicer: ADC-to-bit slicer for the cassette input path.
// A running average over 2**LOG2_DEPTH samples is kept in a circular RAM.
// Each sample is sliced against that average with symmetric hysteresis.
// Optional feature macro: TAPE_SLICER_ACT_EN (tape-activity counter and `active`).
module tape_adc_slicer #(
   parameter int DW          = 12,
   parameter int LOG2_DEPTH  = 9,
   parameter int HYST        = 100,
   parameter int INVERT      = 0,
   parameter int ACT_SAMPLES = 4096
) (
   input  logic             clk,
   input  logic             reset,
   tape_adc_slicer_if.slave bus
);
   localparam int DEPTH = 2 ** LOG2_DEPTH;
   localparam int TW    = DW + LOG2_DEPTH;

   if (LOG2_DEPTH < 1 || HYST < 0 || HYST >= 2 ** DW || ACT_SAMPLES < 1) begin : g_param_check
      $error("tape_adc_slicer: illegal parameter combination");
   end

   // Band edges are evaluated one bit wider than the data, so they never wrap.
   function automatic logic below_band(input logic [DW-1:0] s, input logic [DW-1:0] a);
      return ({1'b0, s} + (DW+1)'(HYST)) < {1'b0, a};
   endfunction

   function automatic logic above_band(input logic [DW-1:0] s, input logic [DW-1:0] a);
      return {1'b0, s} > ({1'b0, a} + (DW+1)'(HYST));
   endfunction

   logic                  sync_d;
   logic                  strobe;
   logic                  vld_p0;
   logic [DW-1:0]         s_p0;
   logic [DW-1:0]         ram_q_p0;
   logic [DW-1:0]         ram [DEPTH];
   logic [LOG2_DEPTH-1:0] wr_ptr;
   logic [LOG2_DEPTH-1:0] rd_addr;
   logic [LOG2_DEPTH-1:0] fill;
   logic [TW-1:0]         total;
   logic [TW-1:0]         new_total;
   logic [DW-1:0]         oldest;
   logic [DW-1:0]         avg_r;
   logic                  primed;
   logic                  raw;
   logic                  raw_nxt;
   logic                  vld_p1;

   // Edge detector on the toggle strobe; follows adc_sync even in reset so no spurious strobe appears on release.
   always_ff @(posedge clk) begin
      sync_d <= bus.adc_sync;
   end

   assign strobe = bus.adc_sync ^ sync_d;

   // ---- stage A: capture sample, read oldest entry ----
   // A sample still in stage B is about to advance wr_ptr, so read one slot ahead of it.
   assign rd_addr = vld_p0 ? LOG2_DEPTH'(wr_ptr + 1'b1) : wr_ptr;

   // Stage A valid and sample capture; a strobe coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      vld_p0 <= strobe & ~reset;
      if (strobe) s_p0 <= bus.adc_data;
   end

   // Circular window RAM: stage B writes the new sample, stage A reads the one it replaces.
   always_ff @(posedge clk) begin
      if (vld_p0) ram[wr_ptr] <= s_p0;
      ram_q_p0 <= ram[rd_addr];
   end

   // ---- stage B: update running sum, average and sliced bit ----
   always_comb begin
      oldest    = primed ? ram_q_p0 : '0;
      new_total = total - TW'(oldest) + TW'(s_p0);
      raw_nxt   = raw;
      if (primed) begin
         if (below_band(s_p0, avg_r))      raw_nxt = 1'b1;
         else if (above_band(s_p0, avg_r)) raw_nxt = 1'b0;
      end
   end

   // Window bookkeeping and slicer state; reset discards any sample in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         total  <= '0;
         wr_ptr <= '0;
         fill   <= '0;
         primed <= 1'b0;
         avg_r  <= '0;
         raw    <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            total  <= new_total;
            wr_ptr <= LOG2_DEPTH'(wr_ptr + 1'b1);
            avg_r  <= new_total[TW-1:LOG2_DEPTH];
            raw    <= raw_nxt;
            if (!primed) begin
               fill <= LOG2_DEPTH'(fill + 1'b1);
               if (&fill) primed <= 1'b1;
            end
         end
      end
   end

   assign bus.dout         = raw ^ (INVERT != 0);
   assign bus.avg          = avg_r;
   assign bus.primed       = primed;
   assign bus.sample_valid = vld_p1;

`ifdef TAPE_SLICER_ACT_EN
   localparam int CW = $clog2(ACT_SAMPLES + 1);
   logic [CW-1:0] act_cnt;

   // Samples since the last dout transition, saturating at ACT_SAMPLES.
   always_ff @(posedge clk) begin
      if (reset) begin
         act_cnt <= CW'(ACT_SAMPLES);
      end else if (vld_p0) begin
         if (raw_nxt != raw)                 act_cnt <= '0;
         else if (act_cnt < CW'(ACT_SAMPLES)) act_cnt <= CW'(act_cnt + 1'b1);
      end
   end

   assign bus.active = primed & (act_cnt < CW'(ACT_SAMPLES));
`else
   assign bus.active = 1'b0;
`endif

endmodule

// File: tb/tb_tape_adc_slicer.sv
// Scoreboard bench for tape_adc_slicer: a window-average model predicts each
// sample_valid response; a negedge monitor pops and compares.
module tb_tape_adc_slicer;
   localparam int DW    = 12;
   localparam int L2D   = 2;
   localparam int DEPTH = 4;
   localparam int HYST  = 100;
   localparam int ACT   = 8;
`ifdef TAPE_SLICER_ACT_EN
   localparam bit ACT_EN = 1'b1;
`else
   localparam bit ACT_EN = 1'b0;
`endif

   typedef struct {
      bit dout;
      int avg;
      bit primed;
      bit active;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   exp_t sbq[$];

   tape_adc_slicer_if #(.DW(DW)) bus ();

   tape_adc_slicer #(
      .DW(DW), .LOG2_DEPTH(L2D), .HYST(HYST), .INVERT(0), .ACT_SAMPLES(ACT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: last DEPTH samples, missing entries count as zero.
   int win[$];
   int m_avg;
   bit m_primed;
   bit m_raw;
   int m_cnt;
   int m_n;

   function automatic void model_reset();
      win.delete();
      m_avg = 0; m_primed = 0; m_raw = 0; m_cnt = ACT; m_n = 0;
   endfunction

   function automatic void model_step(int x);
      int sum;
      bit prev;
      prev = m_raw;
      if (m_primed) begin
         if (x + HYST < m_avg) m_raw = 1;
         else if (x > m_avg + HYST) m_raw = 0;
      end
      win.push_back(x);
      if (win.size() > DEPTH) void'(win.pop_front());
      sum = 0;
      foreach (win[i]) sum += win[i];
      m_avg = sum / DEPTH;
      m_n++;
      if (m_n >= DEPTH) m_primed = 1;
      if (m_raw != prev) m_cnt = 0;
      else if (m_cnt < ACT) m_cnt++;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every sample_valid must match the oldest outstanding prediction.
   always @(negedge clk) begin
      if (bus.sample_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_sample_valid", 1, 0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_dout",    int'(bus.dout),   int'(e.dout));
            chk("sb_avg",     int'(bus.avg),    e.avg);
            chk("sb_primed",  int'(bus.primed), int'(e.primed));
            chk("sb_active",  int'(bus.active), int'(e.active));
            chk("sb_latency", cyc - e.cyc,      2);
         end
      end
   end

   task automatic send(input int x);
      exp_t e;
      @(posedge clk); #1;
      bus.adc_data = DW'(x);
      bus.adc_sync = ~bus.adc_sync;
      model_step(x);
      e.dout   = m_raw;
      e.avg    = m_avg;
      e.primed = m_primed;
      e.active = ACT_EN && (m_cnt < ACT) && m_primed;
      e.cyc    = cyc;
      sbq.push_back(e);
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      sbq.delete();
      model_reset();
   endtask

   task automatic prime(input int x);
      do_reset();
      repeat (DEPTH) send(x);
      settle();
   endtask

   initial begin
      bus.adc_data = '0;
      bus.adc_sync = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_dout",   int'(bus.dout), 0);
      chk("rst_avg",    int'(bus.avg), 0);
      chk("rst_primed", int'(bus.primed), 0);
      chk("rst_valid",  int'(bus.sample_valid), 0);
      chk("rst_active", int'(bus.active), 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Prime with mid-scale.
      repeat (3) send(2048);
      settle();
      chk("prime3_primed", int'(bus.primed), 0);
      send(2048);
      settle();
      chk("prime_primed", int'(bus.primed), 1);
      chk("prime_avg",    int'(bus.avg), 2048);
      chk("prime_dout",   int'(bus.dout), 0);

      // Hysteresis.
      send(1900); settle();
      chk("hyst_low_dout", int'(bus.dout), 1);
      chk("hyst_low_avg",  int'(bus.avg), 2011);
      send(2000); settle();
      chk("hyst_hold_dout", int'(bus.dout), 1);
      chk("hyst_hold_avg",  int'(bus.avg), 1999);
      send(2200); settle();
      chk("hyst_high_dout", int'(bus.dout), 0);

      // Reset coinciding with a strobe.
      send(1900); settle();
      @(posedge clk); #1;
      reset = 1'b1;
      bus.adc_data = DW'(3000);
      bus.adc_sync = ~bus.adc_sync;
      @(posedge clk);
      @(negedge clk);
      chk("rstmid_dout",   int'(bus.dout), 0);
      chk("rstmid_avg",    int'(bus.avg), 0);
      chk("rstmid_primed", int'(bus.primed), 0);
      chk("rstmid_valid",  int'(bus.sample_valid), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      sbq.delete();
      model_reset();
      repeat (3) send(500);
      settle();
      chk("reprime3_primed", int'(bus.primed), 0);
      send(500); settle();
      chk("reprime_primed", int'(bus.primed), 1);

      // Boundaries.
      prime(50);
      send(0); settle();
      chk("bnd_low_dout", int'(bus.dout), 0);
      chk("bnd_low_avg",  int'(bus.avg), 37);
      prime(4095);
      send(4095); settle();
      chk("bnd_high_dout", int'(bus.dout), 0);
      chk("bnd_high_avg",  int'(bus.avg), 4095);

      // Back-to-back strobes.
      do_reset();
      send(10); send(20); send(30); send(40);
      settle();
      chk("b2b_avg",    int'(bus.avg), 25);
      chk("b2b_primed", int'(bus.primed), 1);

      // Activity.
      prime(2048);
      repeat (3) begin send(1900); send(2200); end
      settle();
      chk("act_toggling", int'(bus.active), int'(ACT_EN));
      repeat (ACT - 1) send(2048);
      settle();
      chk("act_quiet7", int'(bus.active), int'(ACT_EN));
      send(2048); settle();
      chk("act_quiet8", int'(bus.active), 0);

      // Randomised traffic with random gaps.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         int gap;
         int x;
         gap = int'($urandom_range(0, 3));
         repeat (gap) @(posedge clk);
         if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 4095));
         else x = 1748 + int'($urandom_range(0, 600));
         send(x);
      end

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      chk("drain_pending", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
